// File: rtl/lcd_dma_if.sv
// lcd_dma_if: CPU-bus handshake, source read port and VRAM write port of the VRAM DMA writer.
interface lcd_dma_if #(
   parameter int VRAM_AW = 13
);
   logic               bus_req;
   logic               bus_gnt;
   logic [15:0]        mem_addr;
   logic               mem_rd;
   logic [7:0]         mem_din;
   logic [VRAM_AW-1:0] vram_addr;
   logic [7:0]         vram_dout;
   logic               vram_we;
   modport master (
      output bus_req, mem_addr, mem_rd, vram_addr, vram_dout, vram_we,
      input  bus_gnt, mem_din
   );
   modport slave (
      input  bus_req, mem_addr, mem_rd, vram_addr, vram_dout, vram_we,
      output bus_gnt, mem_din
   );
endinterface

// File: rtl/lcd_dma.sv
// lcd_dma: copies len*BLK_BYTES bytes from CPU space into LCD VRAM while holding the CPU bus.
// Define LCD_DMA_IRQ_EN to build the completion interrupt flag.
module lcd_dma #(
   parameter int BLK_BYTES = 16,
   parameter int VRAM_AW   = 13
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] reg_addr,
   input  logic [7:0] reg_din,
   input  logic       reg_we,
   output logic [7:0] reg_dout,
   output logic       busy,
   output logic       irq,
   lcd_dma_if.master  bus
);
   localparam int CW = $clog2(256 * BLK_BYTES + 1);
   typedef enum logic [2:0] {IDLE, REQ, RD, WR, DONE} state_t;
   state_t        state;
   logic [15:0]   src, dst;
   logic [7:0]    len;
   logic [CW-1:0] cnt;
   logic          req, we, irq_flag, last, ctrl_wr;
   assign last    = cnt == CW'(1);
   assign ctrl_wr = state == IDLE && reg_we && reg_addr == 3'd5;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         src   <= '0;
         dst   <= '0;
         len   <= '0;
         cnt   <= '0;
         busy  <= 1'b0;
         req   <= 1'b0;
         we    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (reg_we) begin
               case (reg_addr)
                  3'd0: src[7:0]  <= reg_din;
                  3'd1: src[15:8] <= reg_din;
                  3'd2: dst[7:0]  <= reg_din;
                  3'd3: dst[15:8] <= reg_din;
                  3'd4: len       <= reg_din;
                  3'd5: if (reg_din[7]) begin
                     state <= REQ;
                     busy  <= 1'b1;
                     req   <= 1'b1;
                     // len of zero encodes 256 blocks via the ninth bit
                     cnt   <= CW'({~|len, len}) * CW'(BLK_BYTES);
                  end
                  default: ;
               endcase
            end
            REQ: if (bus.bus_gnt) state <= RD;
            RD: begin
               state <= bus.bus_gnt ? WR : REQ;
               we    <= bus.bus_gnt;
            end
            WR: begin
               we                 <= 1'b0;
               src                <= src + 16'd1;
               dst[VRAM_AW-1:0]   <= dst[VRAM_AW-1:0] + VRAM_AW'(1);
               cnt                <= cnt - CW'(1);
               state              <= last ? DONE : RD;
               busy               <= ~last;
               req                <= ~last;
            end
            default: state <= IDLE;
         endcase
      end
   end
`ifdef LCD_DMA_IRQ_EN
   always_ff @(posedge clk) begin
      if (reset) irq_flag <= 1'b0;
      else if (ctrl_wr && reg_din[0]) irq_flag <= 1'b0;
      else if (state == WR && last) irq_flag <= 1'b1;
   end
`else
   assign irq_flag = 1'b0;
`endif
   assign irq           = irq_flag;
   assign bus.bus_req   = req;
   assign bus.mem_rd    = state == RD && bus.bus_gnt;
   assign bus.mem_addr  = src;
   assign bus.vram_addr = dst[VRAM_AW-1:0];
   assign bus.vram_dout = bus.mem_din;
   assign bus.vram_we   = we;
   assign reg_dout = reg_addr == 3'd0 ? src[7:0]  :
                     reg_addr == 3'd1 ? src[15:8] :
                     reg_addr == 3'd2 ? dst[7:0]  :
                     reg_addr == 3'd3 ? dst[15:8] :
                     reg_addr == 3'd4 ? len       :
                     reg_addr == 3'd5 ? {busy, 6'b0, irq_flag} : 8'h00;
endmodule

// File: tb/tb_lcd_dma.sv
// tb_lcd_dma: directed vector table plus hand-written gap, busy-write and reset sequences for lcd_dma.
module tb_lcd_dma;
   logic       clk = 1'b0, reset = 1'b1;
   logic [2:0] reg_addr = '0;
   logic [7:0] reg_din = '0;
   logic       reg_we = 1'b0;
   logic [7:0] reg_dout;
   logic       busy, irq;
   lcd_dma_if #(.VRAM_AW(13)) bus();
   lcd_dma dut (
      .clk(clk), .reset(reset), .reg_addr(reg_addr), .reg_din(reg_din), .reg_we(reg_we),
      .reg_dout(reg_dout), .busy(busy), .irq(irq), .bus(bus)
   );
   always #5 clk = ~clk;
`ifdef LCD_DMA_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif
   typedef struct {
      logic [15:0] s, d;
      logic [7:0]  l, ctrl;
      int          n;
      logic [15:0] fs, fd;
   } vec_t;
   vec_t v[5];
   int ntests = 0, nfail = 0, ncyc = 0, start_cyc = 0, first_we = -1;
   int nwr = 0, nerr = 0, overlap = 0;
   logic [15:0] sb_src = '0, sb_dst = '0;
   function automatic logic [7:0] f(input logic [15:0] a);
      return a[7:0] ^ {a[14:8], a[15]} ^ 8'hA5;
   endfunction
   // source memory: data appears the cycle after mem_rd
   always @(posedge clk) begin
      ncyc++;
      if (bus.mem_rd) bus.mem_din <= f(bus.mem_addr);
   end
   always @(negedge clk) begin
      if (bus.vram_we && bus.mem_rd) overlap++;
      if (bus.vram_we) begin
         if (first_we < 0) first_we = ncyc - start_cyc;
         if (bus.vram_addr !== sb_dst[12:0] || bus.vram_dout !== f(sb_src)) nerr++;
         nwr++;
         sb_src++;
         sb_dst++;
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      reg_addr = a;
      reg_din  = d;
      reg_we   = 1'b1;
      @(negedge clk);
      reg_we = 1'b0;
   endtask
   task automatic rd(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      reg_we   = 1'b0;
      reg_addr = a;
      #1 d = reg_dout;
   endtask
   task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
      wr(3'd0, s[7:0]);
      wr(3'd1, s[15:8]);
      wr(3'd2, d[7:0]);
      wr(3'd3, d[15:8]);
      wr(3'd4, l);
      sb_src = s;
      sb_dst = d;
      nwr = 0;
      nerr = 0;
      first_we = -1;
   endtask
   task automatic start(input logic [7:0] c);
      @(negedge clk);
      reg_addr  = 3'd5;
      reg_din   = c;
      reg_we    = 1'b1;
      start_cyc = ncyc;
   endtask
   task automatic wait_idle(output int cyc, output logic irq1, output logic irq_end);
      cyc = 0;
      irq1 = 1'b0;
      do begin
         @(negedge clk);
         reg_we = 1'b0;
         cyc++;
         if (cyc == 1) irq1 = irq;
      end while (busy && cyc < 20000);
      irq_end = irq;
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask
   task automatic wait_bytes(input int target);
      int k = 0;
      do begin
         @(negedge clk);
         reg_we = 1'b0;
         k++;
      end while (nwr < target && k < 500);
      chk("bytes_timeout", {31'd0, nwr < target}, 32'd0);
   endtask
   task automatic rd16(input logic [2:0] a, output logic [15:0] r);
      logic [7:0] lo, hi;
      rd(a, lo);
      rd(a + 3'd1, hi);
      r = {hi, lo};
   endtask
   initial begin
      int cyc, gap_act;
      logic irq1, irq_end, exp_irq;
      logic [7:0] b;
      logic [15:0] w;
      v[0] = '{16'h8000, 16'h4000, 8'h01, 8'h80, 16,   16'h8010, 16'h4010};
      v[1] = '{16'hFFF8, 16'h0000, 8'h01, 8'h81, 16,   16'h0008, 16'h0010};
      v[2] = '{16'h1234, 16'h5F00, 8'h00, 8'h80, 4096, 16'h2234, 16'h4F00};
      v[3] = '{16'h3000, 16'hFFF8, 8'h01, 8'h81, 16,   16'h3010, 16'hE008};
      v[4] = '{16'h0400, 16'h0123, 8'h03, 8'h80, 48,   16'h0430, 16'h0153};
      bus.bus_gnt = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 6; a++) begin
         rd(3'(a), b);
         chk($sformatf("reset_reg%0d", a), {24'd0, b}, 32'd0);
      end
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_req", {31'd0, bus.bus_req}, 32'd0);
      chk("reset_we", {31'd0, bus.vram_we}, 32'd0);
      chk("reset_rd", {31'd0, bus.mem_rd}, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      exp_irq = 1'b0;
      for (int i = 0; i < 5; i++) begin
         setup(v[i].s, v[i].d, v[i].l);
         if (v[i].ctrl[0]) exp_irq = 1'b0;
         start(v[i].ctrl);
         wait_idle(cyc, irq1, irq_end);
         chk($sformatf("v%0d_writes", i), nwr, v[i].n);
         chk($sformatf("v%0d_bad_bytes", i), nerr, 0);
         chk($sformatf("v%0d_cycles", i), cyc, 2 * v[i].n + 2);
         chk($sformatf("v%0d_latency", i), first_we, 3);
         chk($sformatf("v%0d_irq_busy", i), {31'd0, irq1}, {31'd0, exp_irq});
         chk($sformatf("v%0d_irq_done", i), {31'd0, irq_end}, {31'd0, IRQ_EN});
         rd16(3'd0, w);
         chk($sformatf("v%0d_src", i), {16'd0, w}, {16'd0, v[i].fs});
         rd16(3'd2, w);
         chk($sformatf("v%0d_dst", i), {16'd0, w}, {16'd0, v[i].fd});
         rd(3'd4, b);
         chk($sformatf("v%0d_len", i), {24'd0, b}, {24'd0, v[i].l});
         exp_irq = IRQ_EN;
      end
      rd(3'd5, b);
      chk("ctrl_irq_read", {24'd0, b}, {31'd0, IRQ_EN});
      wr(3'd5, 8'h01);
      chk("irq_cleared", {31'd0, irq}, 32'd0);
      rd(3'd5, b);
      chk("ctrl_after_clear", {24'd0, b}, 32'd0);
      rd(3'd6, b);
      chk("reg6", {24'd0, b}, 32'd0);
      rd(3'd7, b);
      chk("reg7", {24'd0, b}, 32'd0);
      // register writes while busy must be ignored and must not restart
      setup(16'h8000, 16'h4000, 8'h01);
      start(8'h80);
      wait_bytes(3);
      wr(3'd0, 8'hF0);
      wr(3'd5, 8'h80);
      wr(3'd4, 8'h05);
      wait_idle(cyc, irq1, irq_end);
      chk("busywr_writes", nwr, 16);
      chk("busywr_bad_bytes", nerr, 0);
      rd16(3'd0, w);
      chk("busywr_src", {16'd0, w}, 32'h8010);
      rd(3'd4, b);
      chk("busywr_len", {24'd0, b}, 32'h01);
      // grant withdrawn for five cycles mid-transfer
      setup(16'h0100, 16'h0200, 8'h02);
      start(8'h80);
      wait_bytes(5);
      bus.bus_gnt = 1'b0;
      gap_act = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.mem_rd || bus.vram_we) gap_act++;
      end
      chk("gap_req_held", {31'd0, bus.bus_req}, 32'd1);
      bus.bus_gnt = 1'b1;
      wait_idle(cyc, irq1, irq_end);
      chk("gap_activity", gap_act, 0);
      chk("gap_writes", nwr, 32);
      chk("gap_bad_bytes", nerr, 0);
      rd16(3'd0, w);
      chk("gap_src", {16'd0, w}, 32'h0120);
      rd16(3'd2, w);
      chk("gap_dst", {16'd0, w}, 32'h0220);
      // reset during the transfer after byte 7
      setup(16'h8000, 16'h0000, 8'h01);
      start(8'h80);
      wait_bytes(7);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_req", {31'd0, bus.bus_req}, 32'd0);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      chk("rst_writes", nwr, 7);
      rd16(3'd0, w);
      chk("rst_src", {16'd0, w}, 32'd0);
      chk("rd_we_overlap", overlap, 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
